// File: rtl/por_seq_pkg.sv
// por_seq_pkg: shared types and constants for the POR reset sequencer.
// Holds the sequencer state encoding (also visible on seq_state), the
// brownout counter width and a small sizing helper.
package por_seq_pkg;

    localparam int STATE_W  = 3;
    localparam int BO_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD     = 3'd0,
        ST_FILTER   = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAULT    = 3'd6
    } seq_state_t;

    // Largest of three interval lengths; sizes the shared interval counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/por_sync.sv
// por_sync: STAGES-deep flop chain bringing the asynchronous POR output into
// the clk domain. Clears to 0 on rst so the sequencer sees "power bad" until
// a real high has propagated through every stage.
module por_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every stage sampling the previous
        // stage's old value, so the chain really is STAGES flops deep.
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/por_rst_sequencer.sv
// por_rst_sequencer: synchronizes and filters the analog POR output, then
// releases N_DOM reset domains in index order, each release waiting for that
// domain's acknowledge plus an idle gap. A brownout or force_pdn collapses all
// domains back into reset; brownouts after sequencing began are counted.
// Optional feature: define POR_SEQ_ACK_WDT_EN to add an ack watchdog that parks
// the sequencer in FAULT with a sticky ack_err.
module por_rst_sequencer
    import por_seq_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 16,
    parameter int REL_GAP     = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                porb_async,
    input  logic                force_pdn,
    input  logic [N_DOM-1:0]    dom_ack,
    output logic [N_DOM-1:0]    dom_rst,
    output logic                seq_done,
    output logic [STATE_W-1:0]  seq_state,
    output logic [BO_CNT_W-1:0] bo_count,
    output logic                ack_err
);

    // One counter serves the filter window, the release gap and the watchdog.
    localparam int CNT_MAX = max3(FILT_CYC, REL_GAP, ACK_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYC - 1);
    // GAP is entered with cnt = 0 on the ack edge and leaves on cnt == REL_GAP.
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(REL_GAP);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOM - 1);
`ifdef POR_SEQ_ACK_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
`endif

    logic             porb_s;
    logic             kill;
    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    por_sync #(
        .STAGES (SYNC_STAGES)
    ) u_por_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (porb_async),
        .dout (porb_s)
    );

    assign kill      = ~porb_s | force_pdn;
    assign seq_state = state;

`ifdef POR_SEQ_ACK_WDT_EN
    logic ack_err_q;
    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

    // Sequencer FSM with registered domain resets, done flag and brownout count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            idx      <= '0;
            dom_rst  <= '1;
            seq_done <= 1'b0;
            bo_count <= '0;
`ifdef POR_SEQ_ACK_WDT_EN
            ack_err_q <= 1'b0;
`endif
        end else if (kill) begin
            // Power loss or debug power-down beats every transition and every ack.
            if (!porb_s && (state inside {ST_RELEASE, ST_WAIT_ACK, ST_GAP, ST_DONE})
                && (bo_count != '1)) begin
                bo_count <= bo_count + BO_CNT_W'(1);
            end
            state    <= ST_HOLD;
            cnt      <= '0;
            dom_rst  <= '1;
            seq_done <= 1'b0;
`ifdef POR_SEQ_ACK_WDT_EN
            ack_err_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_HOLD: begin
                    dom_rst <= '1;
                    cnt     <= '0;
                    state   <= ST_FILTER;
                end
                ST_FILTER: begin
                    if (cnt == FILT_LAST) begin
                        idx   <= '0;
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    dom_rst[idx] <= 1'b0;
                    cnt          <= '0;
                    state        <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (dom_ack[idx]) begin
                        cnt   <= '0;
                        state <= (idx == LAST_IDX) ? ST_DONE : ST_GAP;
                    end
`ifdef POR_SEQ_ACK_WDT_EN
                    else if (cnt == WDT_LAST) begin
                        dom_rst   <= '1;
                        ack_err_q <= 1'b1;
                        state     <= ST_FAULT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        idx   <= idx + IDX_W'(1);
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    seq_done <= 1'b1;
                end
`ifdef POR_SEQ_ACK_WDT_EN
                ST_FAULT: begin
                    // Parked until kill; domains stay in reset.
                    dom_rst <= '1;
                end
`endif
                default: begin
                    // NOTE: every unused encoding recovers to a safe, fully reset
                    // HOLD rather than leaving state undefined.
                    dom_rst  <= '1;
                    seq_done <= 1'b0;
                    state    <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_por_rst_sequencer.sv
// tb_por_rst_sequencer: self-checking bench for por_rst_sequencer with default
// parameters. Every cycle the DUT outputs are compared with a timeline model
// that counts quiet (non-kill) edges and schedules releases by edge number.
// Directed sections pin the absolute latencies; a randomized section stresses
// glitches, force_pdn pulses and ragged acks. Define POR_SEQ_ACK_WDT_EN for the
// watchdog section.
module tb_por_rst_sequencer;

    localparam int N     = 3;
    localparam int SYNC  = 2;
    localparam int FILT  = 16;
    localparam int GAP   = 8;
    localparam int TMO   = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic         porb_async;
    logic         force_pdn;
    logic [N-1:0] dom_ack;
    logic [N-1:0] dom_rst;
    logic         seq_done;
    logic [2:0]   seq_state;
    logic [7:0]   bo_count;
    logic         ack_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    por_rst_sequencer #(
        .N_DOM       (N),
        .SYNC_STAGES (SYNC),
        .FILT_CYC    (FILT),
        .REL_GAP     (GAP),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .porb_async (porb_async),
        .force_pdn  (force_pdn),
        .dom_ack    (dom_ack),
        .dom_rst    (dom_rst),
        .seq_done   (seq_done),
        .seq_state  (seq_state),
        .bo_count   (bo_count),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (edge-timeline view) ----------------
    bit     ps_pipe[$];     // porb_async samples, newest at front
    int     quiet;          // consecutive non-kill edges since last collapse
    int     released;       // domains released so far
    bit     awaiting;       // waiting for ack of domain released-1
    bit     finished;       // last ack seen
    bit     m_fault;
    int     next_rel;       // edge number of the next release, -1 if none
    bit [N-1:0] m_rst;
    bit     m_done;
    int     m_bo;
    bit     m_err;
`ifdef POR_SEQ_ACK_WDT_EN
    int     wait_since;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_collapse();
        quiet    = 0;
        released = 0;
        awaiting = 0;
        finished = 0;
        m_fault  = 0;
        next_rel = -1;
        m_rst    = '1;
        m_done   = 0;
        m_err    = 0;
    endtask

    task automatic model_edge();
        bit ps;
        bit kill;
        if (rst) begin
            ps_pipe.delete();
            for (int i = 0; i < SYNC; i++) ps_pipe.push_back(1'b0);
            m_bo = 0;
            model_collapse();
            return;
        end
        ps = ps_pipe[SYNC-1];
        ps_pipe.push_front(porb_async);
        void'(ps_pipe.pop_back());
        kill = !ps || force_pdn;
        if (kill) begin
            // Counted only if sequencing had progressed past the filter.
            if (!ps && !m_fault && quiet > FILT && m_bo < 255) m_bo++;
            model_collapse();
        end else begin
            quiet++;
            if (m_fault) begin
                // parked until kill
            end else if (released == 0 && quiet == FILT + 1) begin
                next_rel = cyc + 1;
            end else if (next_rel == cyc) begin
                m_rst[released] = 1'b0;
                released++;
                awaiting = 1;
                next_rel = -1;
`ifdef POR_SEQ_ACK_WDT_EN
                wait_since = cyc;
`endif
            end else if (awaiting && dom_ack[released-1]) begin
                awaiting = 0;
                if (released == N) finished = 1;
                else next_rel = cyc + GAP + 2;
            end
`ifdef POR_SEQ_ACK_WDT_EN
            else if (awaiting && (cyc - wait_since) == TMO) begin
                awaiting = 0;
                m_fault  = 1;
                m_rst    = '1;
                m_err    = 1;
            end
`endif
            else if (finished) begin
                m_done = 1;
            end
        end
    endtask

    function automatic logic [2:0] exp_state();
        if (quiet == 0)         return 3'd0;
        if (m_fault)            return 3'd6;
        if (next_rel == cyc + 1) return 3'd2;
        if (released == 0)      return 3'd1;
        if (awaiting)           return 3'd3;
        if (finished)           return 3'd5;
        return 3'd4;
    endfunction

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic tick();
        logic [31:0] got;
        logic [31:0] exp;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        got = {16'd0, dom_rst, seq_done, seq_state, bo_count, ack_err};
        exp = {16'd0, m_rst, m_done, exp_state(), 8'(m_bo), m_err};
        check("cycle", got, exp);
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (seq_done) break;
            tick();
        end
        check(tag, seq_done, 1'b1);
    endtask

    // Guard against any unbounded hang.
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f0, f1, f2, fd, n;
        bit held;
        int hi_len, lo_len;

        rst = 1'b1; porb_async = 1'b0; force_pdn = 1'b0; dom_ack = '1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        check("rst_dom_rst", dom_rst, 3'b111);
        check("rst_state", seq_state, 3'd0);
        check("rst_bo", bo_count, 8'd0);
        check("rst_done", seq_done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);

        // Rise latency: porb_async goes high right after edge 10.
        f0 = -1; f1 = -1; f2 = -1; fd = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (cyc == 10) porb_async = 1'b1;
            if (f0 < 0 && !dom_rst[0]) f0 = cyc;
            if (f1 < 0 && !dom_rst[1]) f1 = cyc;
            if (f2 < 0 && !dom_rst[2]) f2 = cyc;
            if (fd < 0 && seq_done)    fd = cyc;
        end
        check("rise_dom0_edge", f0, 30);
        check("rise_dom1_edge", f1, 41);
        check("rise_dom2_edge", f2, 52);
        check("rise_done_edge", fd, 54);

        // Brownout from DONE: collapse within three edges and count it.
        porb_async = 1'b0;
        repeat (3) tick();
        check("fall_dom_rst", dom_rst, 3'b111);
        check("fall_done", seq_done, 1'b0);
        check("fall_bo", bo_count, 8'd1);
        repeat (47) tick();
        porb_async = 1'b1;
        wait_done(200, "reseq_done");

        // Short high pulse never releases anything.
        porb_async = 1'b0;
        repeat (10) tick();
        porb_async = 1'b1;
        held = 1;
        repeat (10) begin tick(); if (dom_rst != 3'b111) held = 0; end
        porb_async = 1'b0;
        repeat (6) begin tick(); if (dom_rst != 3'b111) held = 0; end
        check("glitch_held", held, 1'b1);
        check("glitch_state", seq_state, 3'd0);
        check("glitch_bo", bo_count, 8'd2);

        // Stall on a missing ack for domain 1, then resume.
        dom_ack = 3'b101;
        porb_async = 1'b1;
        repeat (100) tick();
        check("stall_state", seq_state, 3'd3);
        check("stall_dom_rst", dom_rst, 3'b100);
        dom_ack = 3'b111;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (!dom_rst[2]) begin n = k; break; end
        end
        check("stall_resume_edges", n, 11);
        wait_done(20, "stall_done");

        // force_pdn in DONE: immediate collapse, no brownout count.
        force_pdn = 1'b1;
        tick();
        check("force_dom_rst", dom_rst, 3'b111);
        check("force_bo", bo_count, 8'd2);
        repeat (5) tick();
        force_pdn = 1'b0;
        n = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (!dom_rst[0]) begin n = k; break; end
        end
        check("force_release_edges", n, FILT + 2);
        wait_done(100, "force_done");

        // Synchronous reset mid-sequence clears everything.
        rst = 1'b1;
        tick();
        check("midrst_dom_rst", dom_rst, 3'b111);
        check("midrst_bo", bo_count, 8'd0);
        check("midrst_state", seq_state, 3'd0);
        rst = 1'b0;

        // Randomized segments: glitches, force pulses, ragged acks.
        for (int s = 0; s < 60; s++) begin
            hi_len = $urandom_range(1, 140);
            lo_len = $urandom_range(1, 20);
            for (int k = 0; k < hi_len; k++) begin
                porb_async = ($urandom_range(0, 99) != 0);
                force_pdn  = ($urandom_range(0, 149) == 0);
                for (int i = 0; i < N; i++) dom_ack[i] = ($urandom_range(0, 3) != 0);
                tick();
            end
            porb_async = 1'b0;
            force_pdn  = 1'b0;
            repeat (lo_len) tick();
        end

        // Repeated brownouts saturate the counter.
        dom_ack = '1;
        for (int r = 0; r < 300; r++) begin
            porb_async = 1'b1;
            wait_done(100, "sat_done");
            porb_async = 1'b0;
            repeat (50) tick();
        end
        check("bo_saturated", bo_count, 8'd255);

`ifdef POR_SEQ_ACK_WDT_EN
        // Missing ack trips the watchdog; a drop clears it.
        dom_ack = '0;
        porb_async = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            if (seq_state == 3'd6) break;
            tick();
        end
        check("wdt_state", seq_state, 3'd6);
        check("wdt_ack_err", ack_err, 1'b1);
        check("wdt_dom_rst", dom_rst, 3'b111);
        porb_async = 1'b0;
        repeat (3) tick();
        check("wdt_exit_state", seq_state, 3'd0);
        check("wdt_exit_ack_err", ack_err, 1'b0);
        check("wdt_exit_bo", bo_count, 8'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
